wb_master_arbiter: RTL

- Two-master, one-slave Wishbone B3 arbiter for the Ethernet MAC subsystem.
- Lets the host configuration master (m0) and the MAC DMA master (m1) share a single slave port, such as the packet buffer memory.
- Round-robin arbitration; a grant is held for the whole cycle, including registered-feedback bursts (cti/bte).

---
 rtl/wb_master_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_master_arbiter.sv
`timescale 1ns/1ps
// wb_master_arbiter: two-master / one-slave Wishbone B3 arbiter.
// m0 = host configuration master, m1 = MAC DMA master, shared slave port.
// Round-robin on contention. Once a master is granted it keeps the slave
// until it drops cyc, so registered-feedback bursts (cti/bte) are never split.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to enable the stalled-strobe
// timeout (limit TIMEOUT_CYCLES); without it, errors come only from the slave.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; slave request outputs low; decide the next owner
// OWN0    | m0 owns the slave; slave port muxed from m0
// OWN1    | m1 owns the slave; slave port muxed from m1

module wb_master_arbiter #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,

  input  logic [WB_ADDR_WIDTH-1:0] m0_wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_wb_sel_i,
  input  logic                     m0_wb_we_i,
  input  logic                     m0_wb_cyc_i,
  input  logic                     m0_wb_stb_i,
  input  logic [2:0]               m0_wb_cti_i,
  input  logic [1:0]               m0_wb_bte_i,
  output logic [WB_DATA_WIDTH-1:0] m0_wb_dat_o,
  output logic                     m0_wb_ack_o,
  output logic                     m0_wb_err_o,

  input  logic [WB_ADDR_WIDTH-1:0] m1_wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_wb_sel_i,
  input  logic                     m1_wb_we_i,
  input  logic                     m1_wb_cyc_i,
  input  logic                     m1_wb_stb_i,
  input  logic [2:0]               m1_wb_cti_i,
  input  logic [1:0]               m1_wb_bte_i,
  output logic [WB_DATA_WIDTH-1:0] m1_wb_dat_o,
  output logic                     m1_wb_ack_o,
  output logic                     m1_wb_err_o,

  output logic [WB_ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0] s_wb_dat_o,
  output logic [WB_SEL_WIDTH-1:0]  s_wb_sel_o,
  output logic                     s_wb_we_o,
  output logic                     s_wb_cyc_o,
  output logic                     s_wb_stb_o,
  output logic [2:0]               s_wb_cti_o,
  output logic [1:0]               s_wb_bte_o,
  input  logic [WB_DATA_WIDTH-1:0] s_wb_dat_i,
  input  logic                     s_wb_ack_i,
  input  logic                     s_wb_err_i,

  output logic [1:0]               grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // last_owner: 0 = m0 was granted last, 1 = m1 was granted last
  logic   last_owner_q, last_owner_d;
  logic   owned;
  logic   own_cyc;
  logic   own_stb;
  logic   timeout_hit;

  assign owned   = (state_q == ST_OWN0) || (state_q == ST_OWN1);
  assign own_cyc = (state_q == ST_OWN0) ? m0_wb_cyc_i :
                   (state_q == ST_OWN1) ? m1_wb_cyc_i : 1'b0;
  assign own_stb = (state_q == ST_OWN0) ? m0_wb_stb_i :
                   (state_q == ST_OWN1) ? m1_wb_stb_i : 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The cycle being judged is counted too, so the watchdog fires on the
  // TIMEOUT_CYCLES-th stalled cycle, when the count reaches the limit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             stalled;

  assign stalled     = owned && own_stb && !s_wb_ack_i && !s_wb_err_i;
  assign timeout_hit = stalled && (to_cnt_q == CNT_LAST);

  // Watchdog counter: counts stalled strobe cycles of the current owner.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= '0;
    end else if (!owned || s_wb_ack_i || s_wb_err_i || timeout_hit ||
                 (state_d == ST_IDLE)) begin
      to_cnt_q <= '0;
    end else if (stalled) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // State and round-robin history registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state: arbitrate from IDLE, release only when the owner drops cyc
  // (cti end-of-burst alone does not release) or the watchdog fires.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          if (last_owner_q) begin
            state_d      = ST_OWN0;
            last_owner_d = 1'b0;
          end else begin
            state_d      = ST_OWN1;
            last_owner_d = 1'b1;
          end
        end else if (m0_wb_cyc_i) begin
          state_d      = ST_OWN0;
          last_owner_d = 1'b0;
        end else if (m1_wb_cyc_i) begin
          state_d      = ST_OWN1;
          last_owner_d = 1'b1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_cyc || timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data is broadcast; only the owner can see ack/err, so this is safe.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  // Slave request mux and response steering. Responses are suppressed while
  // reset is asserted so an in-flight slave ack never reaches a master.
  always_comb begin
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    s_wb_sel_o  = '0;
    s_wb_we_o   = 1'b0;
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_cti_o  = 3'b000;
    s_wb_bte_o  = 2'b00;
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;
    grant_o     = 2'b00;
    unique case (state_q)
      ST_OWN0: begin
        grant_o     = 2'b01;
        s_wb_adr_o  = m0_wb_adr_i;
        s_wb_dat_o  = m0_wb_dat_i;
        s_wb_sel_o  = m0_wb_sel_i;
        s_wb_we_o   = m0_wb_we_i;
        s_wb_cyc_o  = m0_wb_cyc_i && !timeout_hit;
        s_wb_stb_o  = m0_wb_stb_i && !timeout_hit;
        s_wb_cti_o  = m0_wb_cti_i;
        s_wb_bte_o  = m0_wb_bte_i;
        m0_wb_ack_o = s_wb_ack_i && !wb_rst_i;
        m0_wb_err_o = (s_wb_err_i || timeout_hit) && !wb_rst_i;
      end
      ST_OWN1: begin
        grant_o     = 2'b10;
        s_wb_adr_o  = m1_wb_adr_i;
        s_wb_dat_o  = m1_wb_dat_i;
        s_wb_sel_o  = m1_wb_sel_i;
        s_wb_we_o   = m1_wb_we_i;
        s_wb_cyc_o  = m1_wb_cyc_i && !timeout_hit;
        s_wb_stb_o  = m1_wb_stb_i && !timeout_hit;
        s_wb_cti_o  = m1_wb_cti_i;
        s_wb_bte_o  = m1_wb_bte_i;
        m1_wb_ack_o = s_wb_ack_i && !wb_rst_i;
        m1_wb_err_o = (s_wb_err_i || timeout_hit) && !wb_rst_i;
      end
      default: ;
    endcase
  end

endmodule
